// File: rtl/dt_stage.sv
// Data-transfer stage: registers the execute bus, issues one data-memory request per
// memory instruction over req/addr_ok, flags misaligned accesses as ALE and forwards results.
module dt_stage #(
    parameter int DT_TO_MS_BUS_WD = 271,
    parameter int MS_TO_ES_BUS_WD = 38,
    parameter int ALE_BIT         = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [5:0]                 stall,
    input  logic [DT_TO_MS_BUS_WD-1:0] es_to_dts_bus,
    output logic [DT_TO_MS_BUS_WD-1:0] dts_to_ms1_bus,
    output logic [MS_TO_ES_BUS_WD-1:0] dts_to_es_bus,
    output logic                       stallreq_dts,
    output logic                       data_sram_req,
    output logic                       data_sram_wr,
    output logic [1:0]                 data_sram_size,
    output logic [3:0]                 data_sram_wstrb,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    input  logic                       data_sram_addr_ok,
    output logic [1:0]                 dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CSR_LO = 207;
    localparam int REG_WE = 133;

    logic [DT_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic [1:0]                 state_q, state_d;

    function automatic logic is_half(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return b[141] | b[138] | b[135];
    endfunction

    function automatic logic is_word(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return b[140] | b[137] | b[134];
    endfunction

    function automatic logic is_mem(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return |b[142:134];
    endfunction

    function automatic logic is_misaligned(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return (is_half(b) & b[96]) | (is_word(b) & (|b[97:96]));
    endfunction

    function automatic logic is_pre_exc(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return |b[270:207];
    endfunction

    function automatic logic calc_go(input logic [DT_TO_MS_BUS_WD-1:0] b);
        return is_mem(b) & ~is_misaligned(b) & ~is_pre_exc(b);
    endfunction

    logic load_new, bubble, go_in, accept, ale;

    assign bubble   = stall[2] & ~stall[3];
    assign load_new = ~flush & ~stall[2];
    assign go_in    = calc_go(es_to_dts_bus);
    assign accept   = data_sram_req & data_sram_addr_ok;

    always_comb begin
        bus_d = bus_q;
        if (flush || bubble) begin
            bus_d = '0;
        end else if (!stall[2]) begin
            bus_d = es_to_dts_bus;
        end
    end

    // DONE parks an accepted instruction so a downstream hold never re-issues it.
    always_comb begin
        state_d = state_q;
        if (flush || bubble) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = (load_new && go_in) ? REQ : IDLE;
                REQ:     if (accept) state_d = (load_new && go_in) ? REQ : DONE;
                DONE:    if (load_new) state_d = go_in ? REQ : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_q   <= '0;
            state_q <= IDLE;
        end else begin
            bus_q   <= bus_d;
            state_q <= state_d;
        end
    end

    assign ale = is_mem(bus_q) & is_misaligned(bus_q) & ~is_pre_exc(bus_q);

    always_comb begin
        dts_to_ms1_bus                   = bus_q;
        dts_to_ms1_bus[CSR_LO + ALE_BIT] = bus_q[CSR_LO + ALE_BIT] | ale;
        dts_to_ms1_bus[REG_WE]           = bus_q[REG_WE] & ~ale;
    end

    assign dts_to_es_bus = {dts_to_ms1_bus[REG_WE], bus_q[132:128], bus_q[127:96]};

    assign data_sram_addr = bus_q[127:96];
    assign data_sram_wr   = |bus_q[136:134];

    always_comb begin
        data_sram_size = 2'd0;
        if (is_word(bus_q)) begin
            data_sram_size = 2'd2;
        end else if (is_half(bus_q)) begin
            data_sram_size = 2'd1;
        end
    end

    always_comb begin
        data_sram_wstrb = 4'b0000;
        data_sram_wdata = 32'h0;
        if (bus_q[136]) begin
            data_sram_wstrb = 4'b0001 << bus_q[97:96];
            data_sram_wdata = {4{bus_q[71:64]}};
        end else if (bus_q[135]) begin
            data_sram_wstrb = bus_q[97] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{bus_q[79:64]}};
        end else if (bus_q[134]) begin
            data_sram_wstrb = 4'b1111;
            data_sram_wdata = bus_q[95:64];
        end
    end

    assign data_sram_req = (state_q == REQ) & ~flush;
    assign stallreq_dts  = (state_q == REQ) & ~data_sram_addr_ok;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dt_stage.sv
// Directed bench for dt_stage: hand-built execute buses, bench-driven stall/addr_ok,
// expected values written out per scenario.
module tb_dt_stage;

    logic         clk;
    logic         reset;
    logic         flush;
    logic [5:0]   stall;
    logic [270:0] es_to_dts_bus;
    logic [270:0] dts_to_ms1_bus;
    logic [37:0]  dts_to_es_bus;
    logic         stallreq_dts;
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [1:0]   data_sram_size;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;
    logic [1:0]   dbg_state_o;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int acc_base;
    int stall_cycles;

    logic [270:0] b1, b2, b3, b3_exp, b4, b5, b6, b7;

    dt_stage dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .stall             (stall),
        .es_to_dts_bus     (es_to_dts_bus),
        .dts_to_ms1_bus    (dts_to_ms1_bus),
        .dts_to_es_bus     (dts_to_es_bus),
        .stallreq_dts      (stallreq_dts),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .dbg_state_o       (dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: one accepted transaction per edge with req and addr_ok both high.
    always @(posedge clk) begin
        if (data_sram_req && data_sram_addr_ok) acc_cnt++;
    end

    function automatic logic [270:0] make_bus(input logic [63:0] csr_vec, input logic [5:0] load_op,
                                              input logic [2:0] store_op, input logic reg_we,
                                              input logic [4:0] dest, input logic [31:0] result,
                                              input logic [31:0] src1);
        return {csr_vec, 64'h0, load_op, store_op, reg_we, dest, result, src1, 32'h1c00_0000, 32'h0281_0000};
    endfunction

    task automatic check_val(input string tag, input logic [270:0] obs, input logic [270:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall = 6'b0; es_to_dts_bus = '0; data_sram_addr_ok = 1'b0;
        b1 = make_bus(64'h0, 6'b001000, 3'b000, 1'b1, 5'd3, 32'h0000_1000, 32'h0);
        b2 = make_bus(64'h0, 6'b000000, 3'b100, 1'b0, 5'd0, 32'h0000_2003, 32'h0000_00A5);
        b3 = make_bus(64'h0, 6'b010000, 3'b000, 1'b1, 5'd5, 32'h0000_3001, 32'h0);
        b3_exp = make_bus(64'h200, 6'b010000, 3'b000, 1'b0, 5'd5, 32'h0000_3001, 32'h0);
        b4 = make_bus(64'h0, 6'b001000, 3'b000, 1'b1, 5'd7, 32'h0000_5000, 32'h0);
        b5 = make_bus(64'h0, 6'b000000, 3'b010, 1'b0, 5'd0, 32'h0000_4002, 32'h1234_BEEF);
        b6 = make_bus(64'h4, 6'b001000, 3'b000, 1'b1, 5'd9, 32'h0000_6000, 32'h0);
        b7 = make_bus(64'h0, 6'b001000, 3'b000, 1'b1, 5'd2, 32'h0000_7004, 32'h0);

        tick; tick;
        check_val("rst_ms1_bus", dts_to_ms1_bus, '0);
        check_val("rst_es_bus", dts_to_es_bus, '0);
        check_val("rst_req", data_sram_req, 0);
        check_val("rst_stallreq", stallreq_dts, 0);
        check_val("rst_wstrb", data_sram_wstrb, 0);
        check_val("rst_wdata", data_sram_wdata, 0);
        check_val("rst_addr", data_sram_addr, 0);
        check_val("rst_size", data_sram_size, 0);
        check_val("rst_wr", data_sram_wr, 0);
        reset = 1'b0;

        // Aligned word load, zero-wait accept.
        es_to_dts_bus = b1; data_sram_addr_ok = 1'b1;
        tick;
        es_to_dts_bus = '0; #1;
        check_val("ldw_req", data_sram_req, 1);
        check_val("ldw_size", data_sram_size, 2);
        check_val("ldw_wr", data_sram_wr, 0);
        check_val("ldw_wstrb", data_sram_wstrb, 0);
        check_val("ldw_addr", data_sram_addr, 32'h1000);
        check_val("ldw_stallreq", stallreq_dts, 0);
        check_val("ldw_ms1_bus", dts_to_ms1_bus, b1);
        check_val("ldw_es_bus", dts_to_es_bus, {1'b1, 5'd3, 32'h1000});
        tick;
        check_val("ldw_req_done", data_sram_req, 0);
        check_val("ldw_acc", acc_cnt, 1);

        // Byte store with three wait states.
        acc_base = acc_cnt; stall_cycles = 0;
        es_to_dts_bus = b2;
        tick;
        es_to_dts_bus = '0;
        for (int i = 0; i < 3; i++) begin
            data_sram_addr_ok = 1'b0; stall = 6'b001100; #1;
            if (stallreq_dts) stall_cycles++;
            check_val("stb_wait_req", data_sram_req, 1);
            check_val("stb_wstrb", data_sram_wstrb, 4'b1000);
            check_val("stb_wdata", data_sram_wdata, 32'hA5A5_A5A5);
            check_val("stb_size", data_sram_size, 0);
            tick;
        end
        data_sram_addr_ok = 1'b1; stall = 6'b0; #1;
        check_val("stb_stallreq_off", stallreq_dts, 0);
        check_val("stb_req_acc", data_sram_req, 1);
        check_val("stb_wr", data_sram_wr, 1);
        tick;
        check_val("stb_stall_cycles", stall_cycles, 3);
        check_val("stb_acc", acc_cnt - acc_base, 1);
        check_val("stb_req_after", data_sram_req, 0);

        // Misaligned half load raises ALE and kills reg_we.
        acc_base = acc_cnt;
        es_to_dts_bus = b3;
        tick;
        es_to_dts_bus = '0; #1;
        check_val("ale_req", data_sram_req, 0);
        check_val("ale_ms1_bus", dts_to_ms1_bus, b3_exp);
        check_val("ale_es_bus", dts_to_es_bus, {1'b0, 5'd5, 32'h3001});
        tick;
        check_val("ale_acc", acc_cnt - acc_base, 0);

        // Flush arrives together with addr_ok in the second wait cycle.
        es_to_dts_bus = b4; data_sram_addr_ok = 1'b0;
        tick;
        es_to_dts_bus = '0; stall = 6'b001100; #1;
        check_val("fl_wait_stallreq", stallreq_dts, 1);
        tick;
        acc_base = acc_cnt;
        flush = 1'b1; data_sram_addr_ok = 1'b1; #1;
        check_val("fl_req_gated", data_sram_req, 0);
        tick;
        flush = 1'b0; stall = 6'b0; data_sram_addr_ok = 1'b0; #1;
        check_val("fl_ms1_bus", dts_to_ms1_bus, '0);
        check_val("fl_state", dbg_state_o, 2'd0);
        check_val("fl_acc", acc_cnt - acc_base, 0);

        // Half store accepted, then held downstream for four cycles.
        acc_base = acc_cnt;
        es_to_dts_bus = b5; data_sram_addr_ok = 1'b1;
        tick;
        es_to_dts_bus = '0; stall = 6'b011100; #1;
        check_val("sth_req", data_sram_req, 1);
        check_val("sth_wstrb", data_sram_wstrb, 4'b1100);
        check_val("sth_wdata", data_sram_wdata, 32'hBEEF_BEEF);
        check_val("sth_size", data_sram_size, 1);
        tick;
        for (int i = 0; i < 4; i++) begin
            check_val("sth_hold_req", data_sram_req, 0);
            check_val("sth_hold_bus", dts_to_ms1_bus, b5);
            tick;
        end
        stall = 6'b0;
        tick;
        check_val("sth_acc", acc_cnt - acc_base, 1);
        check_val("sth_req_end", data_sram_req, 0);

        // Upstream exception suppresses the request and passes csr_vec through.
        acc_base = acc_cnt;
        es_to_dts_bus = b6;
        tick;
        es_to_dts_bus = '0; #1;
        check_val("exc_req", data_sram_req, 0);
        check_val("exc_ms1_bus", dts_to_ms1_bus, b6);
        tick;
        check_val("exc_acc", acc_cnt - acc_base, 0);

        // Reset while a request is pending.
        acc_base = acc_cnt;
        es_to_dts_bus = b7; data_sram_addr_ok = 1'b0;
        tick;
        es_to_dts_bus = '0; stall = 6'b001100; #1;
        check_val("rstreq_req", data_sram_req, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0; stall = 6'b0; #1;
        check_val("rstreq_req_drop", data_sram_req, 0);
        check_val("rstreq_state", dbg_state_o, 2'd0);
        check_val("rstreq_bus", dts_to_ms1_bus, '0);
        check_val("rstreq_acc", acc_cnt - acc_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dt_stage.md
# dt_stage

Data-transfer stage between execute and `mem1_stage`. Registers the execute-stage bus and issues the data-memory request (address, size, byte strobes, aligned store data) over a req/addr_ok handshake. Detects misaligned accesses and raises ALE in the outgoing exception vector. Forwards the result to execute for bypassing, and requests a pipeline stall while the memory port has not accepted the request.

## Interface

**Parameters**
- `DT_TO_MS_BUS_WD`, default 271: width of the input and output pipeline buses; both use the same field layout.
- `MS_TO_ES_BUS_WD`, default 38: width of the forwarding bus `{reg_we, dest, es_result}`.
- `ALE_BIT`, default 9: index inside `csr_vec` of the address-misalignment exception flag.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: pipeline flush from the exception/ERTN path.
- `stall` in 6: pipeline stall vector; this stage owns `stall[2]`.
- `es_to_dts_bus` in 271: execute bus. Fields:
  - `csr_vec` 270:207
  - `csr_bus` 206:143
  - `load_op` 142:137 = {ld_b, ld_h, ld_w, ld_bu, ld_hu, ll_w}
  - `store_op` 136:134 = {st_b, st_h, st_w}
  - `reg_we` 133
  - `dest` 132:128
  - `es_result` 127:96 (effective address for memory ops)
  - `src1` 95:64 (store data for stores)
  - `pc` 63:32
  - `inst` 31:0
- `dts_to_ms1_bus` out 271: registered bus with `csr_vec` and `reg_we` updated.
- `dts_to_es_bus` out 38: `{reg_we, dest, es_result}` of the held instruction.
- `stallreq_dts` out 1: stall request to the stall controller.
- `data_sram_req` out 1: memory request valid.
- `data_sram_wr` out 1: 1 = store.
- `data_sram_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_sram_wstrb` out 4: byte write strobes; 0 for loads.
- `data_sram_addr` out 32: byte address, equal to `es_result`.
- `data_sram_wdata` out 32: store data replicated into lane position.
- `data_sram_addr_ok` in 1: memory port accepts the request this cycle.

## Operation

**Pipeline register (`bus_r`), priority order**
1. `reset` → 0.
2. `flush` → 0.
3. `stall[2] & !stall[3]` → 0 (bubble).
4. `!stall[2]` → load `es_to_dts_bus`.
5. Otherwise hold.

**Decode on `bus_r`**
- mem_op = |load_op | |store_op.
- size: b = 0, h = 1, w / ll_w = 2.
- Misaligned:
  - half access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0.
- pre_exc = |csr_vec (exception already raised upstream).
- go = mem_op & !misaligned & !pre_exc.

**Output bus**
- Equals `bus_r`, except:
  - csr_vec[ALE_BIT] = csr_vec[ALE_BIT] | (mem_op & misaligned & !pre_exc);
  - reg_we is forced to 0 when ALE is raised here.
- All other fields pass through unchanged.

**Store lane formatting**
- st_b: wdata = {4{src1[7:0]}}, wstrb = 4'b0001 << addr[1:0].
- st_h: wdata = {2{src1[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
- st_w: wdata = src1, wstrb = 4'b1111.
- Loads: wstrb = 0, wdata = 0.

**Request FSM**
- States: IDLE, REQ, DONE. Reset → IDLE.
- IDLE → REQ: when a new bus is loaded (case 4 above) and go evaluates true on the loaded value. Otherwise stay in IDLE.
- REQ → DONE: on `data_sram_addr_ok & data_sram_req`.
- DONE → REQ: on a new load with go; DONE → IDLE: on a new load without go. Otherwise stay in DONE. DONE guarantees exactly one request per instruction while downstream stalls hold it.
- `flush`, a bubble (case 3) or `reset` → IDLE, regardless of state.

**Request and stall outputs**
- `data_sram_req` = (state == REQ) & !flush.
- `stallreq_dts` = (state == REQ) & !data_sram_addr_ok.
- The request outputs (addr, size, wr, wstrb, wdata) are combinational from `bus_r` and stay stable while `req` = 1.
- `dts_to_es_bus` takes reg_we after the ALE override.

## Timing

- Output reset values:
  - `dts_to_ms1_bus` = 0, `dts_to_es_bus` = 0;
  - `data_sram_req` = 0, `stallreq_dts` = 0;
  - `wstrb` = 0, `wdata` = 0, `addr` = 0, `size` = 0, `wr` = 0.
- Latency:
  - instruction on `es_to_dts_bus` at edge N appears on `dts_to_ms1_bus` and drives `req` in cycle N+1;
  - zero-wait accept (`addr_ok` = 1 in N+1) → no stall, DONE at N+2.
- Wait states: each cycle with REQ and `addr_ok` = 0 asserts `stallreq_dts`. The controller then sets `stall[2]` and `stall[3]`, so `bus_r` holds; `stall[4]` may be 0, so mem1 receives bubbles.
- `flush` coincident with `addr_ok`: `req` is already gated low, so no transaction occurs; state → IDLE.
- `reset` mid-REQ: `req` drops the next cycle, no acceptance is recorded, and the FSM returns to IDLE.
- Bubble insertion while in DONE clears `bus_r`, and the FSM goes to IDLE.

## Test plan

- **Aligned word load:** ld_w, addr 0x1000, `addr_ok` = 1 → one cycle of `req` = 1 with size = 2, wr = 0, wstrb = 0; `stallreq_dts` never asserts; the bus reaches mem1 unchanged.
- **Byte store with wait states:** st_b, addr 0x2003, src1 = 0x000000A5, `addr_ok` low for 3 cycles → wstrb = 4'b1000 and wdata = 0xA5A5A5A5 held stable; `stallreq_dts` = 1 for exactly 3 cycles; exactly one accepted request.
- **Misaligned half load:** ld_h, addr 0x3001 → `req` never asserts; csr_vec[ALE_BIT] = 1 and reg_we = 0 on both `dts_to_ms1_bus` and `dts_to_es_bus`.
- **Flush during REQ:** flush asserted in the second waiting cycle while `addr_ok` = 1 → `req` = 0 that cycle, no transaction; next cycle `bus_r` = 0 and state is IDLE.
- **Downstream hold after accept:** st_h at 0x4002 accepted in cycle 1, then `stall[2]`, `stall[3]` and `stall[4]` held for 4 cycles → no second `req`; wstrb was 4'b1100.
- **Upstream exception:** an instruction with csr_vec ≠ 0 and ld_w → no `req`, and csr_vec passes through unchanged.
